// File: rtl/param_sync_fifo_pkg.sv
// ----------------------------------------------------------------------------
// param_sync_fifo_pkg
// Shared definitions for the parameterised single-clock FIFO:
//   - read-mode constants (show-ahead vs registered output)
//   - pointer / address width derivation from DEPTH
//   - parameter legality check used at elaboration
//   - sticky error flag bundle
// No ports (package).
// ----------------------------------------------------------------------------
package param_sync_fifo_pkg;

    // Read-mode selector values for the FWFT parameter.
    localparam int FWFT_OFF = 0;  // rd_data registered, valid one cycle after read
    localparam int FWFT_ON  = 1;  // head word visible on rd_data with zero latency

    // Address width for a DEPTH-entry memory (DEPTH is a power of two >= 2).
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Pointer width: one extra wrap bit above the address so that a full
    // FIFO and an empty FIFO are distinguishable with equal low bits.
    function automatic int ptr_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    // True when every parameter lies inside its legal range.
    function automatic bit params_ok(
        input int data_w,
        input int depth,
        input int afull_th,
        input int aempty_th,
        input int fwft
    );
        return (data_w >= 1)
            && is_pow2(depth)
            && (afull_th >= 1) && (afull_th <= depth)
            && (aempty_th >= 0) && (aempty_th <= depth - 1)
            && ((fwft == FWFT_OFF) || (fwft == FWFT_ON));
    endfunction

    // Sticky error flags; set by rejected requests, cleared by flush/reset.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } sticky_t;

endpackage

// File: rtl/param_sync_fifo_if.sv
// ----------------------------------------------------------------------------
// param_sync_fifo_if
// Bundles the FIFO's request, data and status signals.
//   master : the producer/consumer side (drives flush/wr/wr_data/rd)
//   slave  : the FIFO itself (drives read data and all status)
// Signals:
//   flush        sync clear of contents and sticky flags
//   wr, wr_data  write request and data
//   rd           read request
//   rd_data      read data (combinational head or registered, per FWFT)
//   rd_valid     registered mode: rd_data valid; show-ahead mode: ~empty
//   full/empty/almost_full/almost_empty   occupancy status
//   count        occupancy 0..DEPTH
//   overflow/underflow  sticky rejected-request flags
// ----------------------------------------------------------------------------
interface param_sync_fifo_if
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
);
    localparam int CW = ptr_w(DEPTH);

    logic              flush;
    logic              wr;
    logic [DATA_W-1:0] wr_data;
    logic              rd;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr, wr_data, rd,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, wr, wr_data, rd,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/param_sync_fifo_ptr.sv
// ----------------------------------------------------------------------------
// param_sync_fifo_ptr
// PW-bit wrapping pointer used for both the FIFO write and read pointers.
// The MSB is the wrap bit; the counter rolls over naturally at 2^PW.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset (pointer -> 0)
//   clr_i   synchronous clear (pointer -> 0), has priority over inc_i
//   inc_i   advance pointer by one
//   ptr_o   current pointer value
// ----------------------------------------------------------------------------
module param_sync_fifo_ptr #(
    parameter int PW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        // NOTE: default assignment first so every path assigns ptr_d and no latch is inferred.
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for state so all flops update together at the edge.
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/param_sync_fifo.sv
// ----------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO with parameterised width/depth, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush, sticky
// overflow/underflow flags and a choice of show-ahead or registered read.
// Parameters:
//   DATA_W     data word width (>= 1)
//   DEPTH      entries, power of two >= 2
//   AFULL_TH   almost_full when count >= AFULL_TH (1..DEPTH)
//   AEMPTY_TH  almost_empty when count <= AEMPTY_TH (0..DEPTH-1)
//   FWFT       1: head word on rd_data combinationally; 0: registered read
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        param_sync_fifo_if slave modport (requests in, data/status out)
// ----------------------------------------------------------------------------
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = FWFT_ON
) (
    input  logic             clk,
    input  logic             rst_n,
    param_sync_fifo_if.slave bus
);

    localparam int AW = addr_w(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_TH);

    // ------------------------------------------------------------------
    // Elaboration-time parameter check
    // ------------------------------------------------------------------
    if (!params_ok(DATA_W, DEPTH, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
        $error("param_sync_fifo: illegal parameters DATA_W=%0d DEPTH=%0d AFULL_TH=%0d AEMPTY_TH=%0d FWFT=%0d",
               DATA_W, DEPTH, AFULL_TH, AEMPTY_TH, FWFT);
    end

    // ------------------------------------------------------------------
    // Pointers and status (all status derived from registered pointers,
    // so it never glitches with wr/rd)
    // ------------------------------------------------------------------
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] count_w;
    logic          full_w;
    logic          empty_w;
    logic          wr_acc;
    logic          rd_acc;

    assign empty_w = (wptr == rptr);
    assign full_w  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count_w = wptr - rptr;

    // A write into a full FIFO is still accepted when the head is read in
    // the same cycle: the head leaves before its slot is rewritten.
    // Reads from an empty FIFO are rejected even when a write arrives
    // alongside, since wr_data is never bypassed to the output.
    assign rd_acc = bus.rd & ~empty_w & ~bus.flush;
    assign wr_acc = bus.wr & (~full_w | rd_acc) & ~bus.flush;

    param_sync_fifo_ptr #(.PW(PW)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .inc_i (wr_acc),
        .ptr_o (wptr)
    );

    param_sync_fifo_ptr #(.PW(PW)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (bus.flush),
        .inc_i (rd_acc),
        .ptr_o (rptr)
    );

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto distributed RAM; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr[AW-1:0]] <= bus.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    sticky_t sticky_q;
    sticky_t sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (bus.flush) begin
            sticky_d = '0;
        end else begin
            if (bus.wr && !wr_acc) sticky_d.overflow  = 1'b1;
            if (bus.rd && !rd_acc) sticky_d.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    // ------------------------------------------------------------------
    // Read output path
    // ------------------------------------------------------------------
    if (FWFT == FWFT_ON) begin : g_showahead
        // Head word is always presented; contents are don't-care while empty.
        assign bus.rd_data  = mem[rptr[AW-1:0]];
        assign bus.rd_valid = ~empty_w;
    end else begin : g_registered
        logic [DATA_W-1:0] rd_data_q;
        logic [DATA_W-1:0] rd_data_d;
        logic              rd_valid_q;
        logic              rd_valid_d;

        // rd_data holds its last value when no read is accepted, including
        // across a flush; only rd_valid drops.
        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
            if (rd_acc) begin
                rd_data_d  = mem[rptr[AW-1:0]];
                rd_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.count        = count_w;
    assign bus.almost_full  = (count_w >= AFULL_LVL);
    assign bus.almost_empty = (count_w <= AEMPTY_LVL);
    assign bus.overflow     = sticky_q.overflow;
    assign bus.underflow    = sticky_q.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_param_sync_fifo
// Scoreboard bench for param_sync_fifo. Two instances share the clock:
//   dut_a : FWFT=1 (show-ahead), DEPTH=16, AFULL_TH=12, AEMPTY_TH=2
//   dut_b : FWFT=0 (registered read), same geometry
// Stimulus pushes each word the FIFO should accept into a per-DUT queue;
// monitors pop and compare whenever a DUT presents read data.
// ----------------------------------------------------------------------------
module tb_param_sync_fifo;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) ia ();
    param_sync_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) ib ();

    param_sync_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (ia)
    );

    param_sync_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ib)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    int          cnt_a = 0;
    int          cnt_b = 0;
    logic        ovf_a = 1'b0;
    logic        udf_a = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus on dut_a; called at posedge+1, returns at
    // the next posedge+1. Expected words are queued after the edge so the
    // monitor (negedge) only sees words that were stored before this cycle.
    task automatic step_a(input logic w, input logic [63:0] d, input logic r, input logic f);
        logic wa;
        logic ra;
        ra = r && (cnt_a > 0) && !f;
        wa = w && ((cnt_a < DEPTH) || ra) && !f;
        ia.wr = w; ia.wr_data = d; ia.rd = r; ia.flush = f;
        @(posedge clk);
        #1;
        ia.wr = 1'b0; ia.rd = 1'b0; ia.flush = 1'b0;
        if (f) begin
            q_a.delete();
            cnt_a = 0;
            ovf_a = 1'b0;
            udf_a = 1'b0;
        end else begin
            if (w && !wa) ovf_a = 1'b1;
            if (r && !ra) udf_a = 1'b1;
            if (wa) q_a.push_back(d);
            cnt_a = cnt_a + int'(wa) - int'(ra);
        end
    endtask

    task automatic step_b(input logic w, input logic [63:0] d, input logic r);
        logic wa;
        logic ra;
        ra = r && (cnt_b > 0);
        wa = w && ((cnt_b < DEPTH) || ra);
        ib.wr = w; ib.wr_data = d; ib.rd = r; ib.flush = 1'b0;
        @(posedge clk);
        #1;
        ib.wr = 1'b0; ib.rd = 1'b0;
        if (wa) q_b.push_back(d);
        cnt_b = cnt_b + int'(wa) - int'(ra);
    endtask

    // Show-ahead monitor: a word is consumed when rd is high mid-cycle.
    always @(negedge clk) begin
        if (rst_n_a && ia.rd && !ia.flush) begin
            check("a_rd_valid", ia.rd_valid, q_a.size() != 0);
            if (ia.rd_valid && q_a.size() != 0) begin
                check("a_rd_data", ia.rd_data, q_a.pop_front());
            end
        end
    end

    // Registered-read monitor: a word is presented while rd_valid is high.
    always @(negedge clk) begin
        if (rst_n_b && ib.rd_valid) begin
            check("b_word_expected", q_b.size() != 0, 1'b1);
            if (q_b.size() != 0) begin
                check("b_rd_data", ib.rd_data, q_b.pop_front());
            end
        end
    end

    initial begin
        ia.flush = 1'b0; ia.wr = 1'b0; ia.wr_data = '0; ia.rd = 1'b0;
        ib.flush = 1'b0; ib.wr = 1'b0; ib.wr_data = '0; ib.rd = 1'b0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- reset state ----------------
        check("rst_a_empty",        ia.empty,        1);
        check("rst_a_full",         ia.full,         0);
        check("rst_a_count",        ia.count,        0);
        check("rst_a_almost_empty", ia.almost_empty, 1);
        check("rst_a_almost_full",  ia.almost_full,  0);
        check("rst_a_overflow",     ia.overflow,     0);
        check("rst_a_underflow",    ia.underflow,    0);
        check("rst_a_rd_valid",     ia.rd_valid,     0);
        check("rst_b_rd_valid",     ib.rd_valid,     0);
        check("rst_b_rd_data",      ib.rd_data,      0);
        check("rst_b_count",        ib.count,        0);

        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- fill 0x0..0xF ----------------
        for (int i = 0; i < 16; i++) begin
            step_a(1'b1, 64'(i), 1'b0, 1'b0);
            check("fill_count",       ia.count,       64'(i + 1));
            check("fill_almost_full", ia.almost_full, 64'((i + 1) >= 12));
            check("fill_full",        ia.full,        64'((i + 1) == 16));
        end
        check("fill_no_overflow", ia.overflow, 0);

        // ---------------- write while full ----------------
        step_a(1'b1, 64'hDEAD, 1'b0, 1'b0);
        check("ovf_set",   ia.overflow, 1);
        check("ovf_count", ia.count,    16);
        step_a(1'b0, '0, 1'b0, 1'b0);
        check("ovf_sticky", ia.overflow, 1);

        // Drain: monitor expects 0x0..0xF in order.
        for (int i = 0; i < 16; i++) begin
            step_a(1'b0, '0, 1'b1, 1'b0);
            check("drain_almost_empty", ia.almost_empty, 64'((15 - i) <= 2));
        end
        check("drain_empty",         ia.empty,    1);
        check("drain_count",         ia.count,    0);
        check("drain_ovf_still_set", ia.overflow, 1);

        // ---------------- read while empty, then flush ----------------
        step_a(1'b0, '0, 1'b1, 1'b0);
        check("udf_set",   ia.underflow, 1);
        check("udf_count", ia.count,     0);
        step_a(1'b0, '0, 1'b0, 1'b1);
        check("flush_udf_clr", ia.underflow, 0);
        check("flush_ovf_clr", ia.overflow,  0);
        check("flush_empty",   ia.empty,     1);

        // ---------------- empty + wr + rd ----------------
        step_a(1'b1, 64'h77, 1'b1, 1'b0);
        check("ewr_count",     ia.count,     1);
        check("ewr_underflow", ia.underflow, 1);
        check("ewr_empty",     ia.empty,     0);
        step_a(1'b0, '0, 1'b1, 1'b0);
        check("ewr_drained", ia.empty, 1);

        // ---------------- flush with data; write during flush ignored ----------------
        step_a(1'b1, 64'h31, 1'b0, 1'b0);
        step_a(1'b1, 64'h32, 1'b0, 1'b0);
        step_a(1'b1, 64'h33, 1'b0, 1'b0);
        step_a(1'b1, 64'h34, 1'b0, 1'b1);
        check("flushd_count", ia.count,     0);
        check("flushd_empty", ia.empty,     1);
        check("flushd_udf",   ia.underflow, 0);
        step_a(1'b1, 64'h40, 1'b0, 1'b0);
        step_a(1'b0, '0, 1'b1, 1'b0);
        check("flushd_after", ia.empty, 1);

        // ---------------- full + wr + rd ----------------
        for (int i = 0; i < 16; i++) step_a(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0);
        check("frw_full_before", ia.full, 1);
        step_a(1'b1, 64'hAA, 1'b1, 1'b0);
        check("frw_count",    ia.count,    16);
        check("frw_full",     ia.full,     1);
        check("frw_overflow", ia.overflow, 0);
        for (int i = 0; i < 16; i++) step_a(1'b0, '0, 1'b1, 1'b0);
        check("frw_empty", ia.empty, 1);

        // ---------------- random interleave across pointer wraps ----------------
        step_a(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            logic       w;
            logic       r;
            logic [63:0] d;
            w = ($urandom_range(3) != 0);
            r = ($urandom_range(3) != 0);
            d = {$urandom, $urandom};
            step_a(w, d, r, 1'b0);
            check("rnd_count", ia.count, 64'(cnt_a));
        end
        check("rnd_overflow",  ia.overflow,  ovf_a);
        check("rnd_underflow", ia.underflow, udf_a);
        for (int i = 0; i < DEPTH && cnt_a > 0; i++) step_a(1'b0, '0, 1'b1, 1'b0);
        check("rnd_empty", ia.empty, 1);

        // ---------------- registered read (dut_b) ----------------
        step_b(1'b1, 64'h55, 1'b0);
        check("reg_valid_before", ib.rd_valid, 0);
        step_b(1'b0, '0, 1'b1);
        check("reg_valid_after", ib.rd_valid, 1);
        check("reg_data_after",  ib.rd_data,  64'h55);
        step_b(1'b0, '0, 1'b0);
        check("reg_valid_drop", ib.rd_valid, 0);
        check("reg_data_hold",  ib.rd_data,  64'h55);

        for (int i = 0; i < 4; i++) step_b(1'b1, 64'h60 + 64'(i), 1'b0);
        for (int i = 0; i < 4; i++) step_b(1'b0, '0, 1'b1);
        step_b(1'b0, '0, 1'b0);
        check("reg_burst_empty", ib.empty, 1);

        // ---------------- async reset mid-burst (dut_b) ----------------
        step_b(1'b0, '0, 1'b1);
        check("mid_udf_set", ib.underflow, 1);
        for (int i = 0; i < 5; i++) step_b(1'b1, 64'h70 + 64'(i), 1'b0);
        check("mid_count_pre", ib.count, 5);
        ib.wr = 1'b1; ib.wr_data = 64'h75; ib.rd = 1'b1;
        @(posedge clk);
        #1;
        check("mid_valid_pre", ib.rd_valid, 1);
        #1;
        rst_n_b = 1'b0;
        q_b.delete();
        cnt_b = 0;
        #1;
        check("mid_rst_count",        ib.count,        0);
        check("mid_rst_empty",        ib.empty,        1);
        check("mid_rst_full",         ib.full,         0);
        check("mid_rst_almost_empty", ib.almost_empty, 1);
        check("mid_rst_almost_full",  ib.almost_full,  0);
        check("mid_rst_overflow",     ib.overflow,     0);
        check("mid_rst_underflow",    ib.underflow,    0);
        check("mid_rst_rd_valid",     ib.rd_valid,     0);
        check("mid_rst_rd_data",      ib.rd_data,      0);
        ib.wr = 1'b0; ib.rd = 1'b0;
        @(posedge clk);
        #1;
        rst_n_b = 1'b1;
        @(posedge clk);
        #1;
        step_b(1'b1, 64'h99, 1'b0);
        step_b(1'b0, '0, 1'b1);
        check("post_rst_valid", ib.rd_valid, 1);
        step_b(1'b0, '0, 1'b0);

        // Every queued word must have been presented by its DUT.
        check("a_queue_drained", 64'(q_a.size()), 0);
        check("b_queue_drained", 64'(q_b.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
